seg7_scan_mux: RTL and testbench



---
 rtl/seg7_scan_pkg.sv | 19 +
 rtl/seg7_hex_decode.sv | 15 +
 rtl/seg7_scan_mux.sv | 192 +++++++++++++++++++
 tb/tb_seg7_scan_mux.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_pkg.sv
// Shared types and constants for the seven-segment scan multiplexer.
//   state_t    : scan FSM states (GUARD = all digits dark, SCAN = one digit lit)
//   SEG_LUT    : hex value -> active-high {g,f,e,d,c,b,a} segment pattern
//   cnt_width  : width of the dwell counter, large enough for the longer phase
package seg7_scan_pkg;

  typedef enum logic {GUARD = 1'b0, SCAN = 1'b1} state_t;

  // Entry 0 is the rightmost element, so the list reads F..0 from left to right.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int cnt_width(input int scan_div, input int blank_cycles);
    return $clog2(((scan_div > blank_cycles) ? scan_div : blank_cycles) + 1);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-seven-segment decoder.
//   value : 4-bit digit value (0..F)
//   blank : force all segments off
//   seg   : active-high segments {g,f,e,d,c,b,a}
module seg7_hex_decode
  import seg7_scan_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? 7'd0 : SEG_LUT[value];

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed driver for a common-cathode seven-segment display.
// Each digit is lit for SCAN_DIV cycles, followed by BLANK_CYCLES with every
// digit dark to stop ghosting. Digit values are double-buffered: load fills a
// shadow copy, which moves into the displayed copy only at a frame boundary.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   ena         : scan enable; low freezes the scan and darkens the display
//   digits_in   : 4 bits per digit, digit 0 in [3:0]
//   dp_in       : decimal point per digit
//   load        : capture digits_in/dp_in into the shadow copy
//   segments    : active-high {g,f,e,d,c,b,a}
//   dp_out      : active-high decimal point
//   digit_sel   : one-hot active-high digit enable
//   frame_done  : pulses during the final guard cycle of each frame
//
// Build option: define LZ_BLANK_EN to suppress leading zeros (digit 0 is
// always shown; decimal points stay driven on suppressed digits).
module seg7_scan_mux
  import seg7_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 250,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  output logic [6:0]                segments,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     digit_sel,
  output logic                      frame_done
);

  localparam int CW = cnt_width(SCAN_DIV, BLANK_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_t                       state, state_nxt;
  logic [CW-1:0]                cnt, cnt_nxt;
  logic [IW-1:0]                idx, idx_nxt;
  logic                         wrap;

  logic [NUM_DIGITS-1:0][3:0]   shadow_dig, active_dig, active_dig_nxt;
  logic [NUM_DIGITS-1:0]        shadow_dp, active_dp, active_dp_nxt;
  logic                         pending;

  logic [NUM_DIGITS-1:0]        lz_mask;
  logic [NUM_DIGITS-1:0]        sel_nxt;
  logic [6:0]                   seg_nxt;
  logic                         dp_nxt, fd_nxt, seg_blank;

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GUARD;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // The index advances on the way into GUARD, so each guard belongs to the
  // digit it precedes. That lets reset (GUARD, index 0) lead straight into
  // digit 0, and makes "guard ends with index 0" the frame boundary.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    wrap      = 1'b0;
    if (ena) begin
      unique case (state)
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            state_nxt = GUARD;
            cnt_nxt   = '0;
            idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        GUARD: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = SCAN;
            cnt_nxt   = '0;
            wrap      = (idx == '0);
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------- display buffers
  // The transfer happens on the same edge that lights digit 0, so the decode
  // looks at the post-transfer value to show the new frame from its start.
  always_comb begin
    active_dig_nxt = active_dig;
    active_dp_nxt  = active_dp;
    if (wrap && pending) begin
      active_dig_nxt = shadow_dig;
      active_dp_nxt  = shadow_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_dig <= '0;
      shadow_dp  <= '0;
      active_dig <= '0;
      active_dp  <= '0;
      pending    <= 1'b0;
    end else begin
      active_dig <= active_dig_nxt;
      active_dp  <= active_dp_nxt;
      // A load on the transfer edge keeps pending set: the value it brings
      // has not been shown yet.
      if (load) begin
        shadow_dig <= digits_in;
        shadow_dp  <= dp_in;
        pending    <= 1'b1;
      end else if (wrap) begin
        pending    <= 1'b0;
      end
    end
  end

  // ------------------------------------------------- leading-zero suppression
`ifdef LZ_BLANK_EN
  logic zero_run;
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run & (active_dig_nxt[i] == 4'd0);
      lz_mask[i] = zero_run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  // ------------------------------------------------------------ outputs
  // Outputs are registered from the next state so digit_sel lines up with
  // the FSM phase rather than trailing it by a cycle.
  always_comb begin
    sel_nxt   = '0;
    dp_nxt    = 1'b0;
    seg_blank = 1'b1;
    fd_nxt    = frame_done;
    if (ena) begin
      fd_nxt = (state_nxt == GUARD) && (cnt_nxt == BLANK_LAST) && (idx_nxt == '0);
      if (state_nxt == SCAN) begin
        sel_nxt   = NUM_DIGITS'(1) << idx_nxt;
        dp_nxt    = active_dp_nxt[idx_nxt];
        seg_blank = lz_mask[idx_nxt];
      end
    end
  end

  seg7_hex_decode u_dec (
    .value (active_dig_nxt[idx_nxt]),
    .blank (seg_blank),
    .seg   (seg_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel  <= '0;
      segments   <= '0;
      dp_out     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      digit_sel  <= sel_nxt;
      segments   <= seg_nxt;
      dp_out     <= dp_nxt;
      frame_done <= fd_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux with NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=2.
// A frame-position model predicts every output on every cycle; directed
// steps add literal expectations for specific digits.
module tb_seg7_scan_mux;

  localparam int N = 4;
  localparam int S = 4;
  localparam int B = 2;
  localparam int P = N * (S + B);

`ifdef LZ_BLANK_EN
  localparam logic [6:0] ZSEG = 7'h00;
`else
  localparam logic [6:0] ZSEG = 7'h3F;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [15:0]   digits_in = '0;
  logic [3:0]    dp_in = '0;
  logic          load = 1'b0;
  logic [6:0]    segments;
  logic          dp_out;
  logic [3:0]    digit_sel;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  seg7_scan_mux #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .digits_in(digits_in), .dp_in(dp_in),
    .load(load), .segments(segments), .dp_out(dp_out), .digit_sel(digit_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  function automatic logic [6:0] hexseg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  int          pos = 0;          // enabled cycles since reset, modulo P
  logic [15:0] m_sh = '0, m_act = '0;
  logic [3:0]  m_shdp = '0, m_actdp = '0;
  bit          m_pend = 0;
  logic [3:0]  e_sel = '0;
  logic [6:0]  e_seg = '0;
  logic        e_dp = 1'b0, e_fd = 1'b0;

  function automatic logic [6:0] model_seg(input int d);
`ifdef LZ_BLANK_EN
    if (d > 0) begin
      bit allz = 1;
      for (int j = d; j < N; j++) if (m_act[4*j +: 4] != 4'd0) allz = 0;
      if (allz) return 7'h00;
    end
`endif
    return hexseg(m_act[4*d +: 4]);
  endfunction

  // Frame position 0 is the first cycle of digit 0; reset starts in the
  // guard ahead of it, i.e. at position P-B.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos = 0; m_sh = '0; m_act = '0; m_shdp = '0; m_actdp = '0; m_pend = 0;
      e_sel = '0; e_seg = '0; e_dp = 1'b0; e_fd = 1'b0;
    end else begin
      int fp, dig, off;
      bit wrp;
      fp  = (pos + P - B) % P;
      wrp = ena && (fp == P - 1);
      if (wrp && m_pend) begin m_act = m_sh; m_actdp = m_shdp; end
      if (load) begin m_sh = digits_in; m_shdp = dp_in; m_pend = 1; end
      else if (wrp) m_pend = 0;
      if (ena) begin
        pos  = (pos + 1) % P;
        fp   = (pos + P - B) % P;
        dig  = fp / (S + B);
        off  = fp % (S + B);
        e_fd = (fp == P - 1);
        if (off < S) begin
          e_sel = 4'(1 << dig); e_seg = model_seg(dig); e_dp = m_actdp[dig];
        end else begin
          e_sel = '0; e_seg = '0; e_dp = 1'b0;
        end
      end else begin
        e_sel = '0; e_seg = '0; e_dp = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_digit_sel", digit_sel, e_sel);
    chk("model_segments", segments, e_seg);
    chk("model_dp_out", dp_out, e_dp);
    chk("model_frame_done", frame_done, e_fd);
  end

  // ------------------------------------------------------------ helpers
  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
    load = 1'b1; digits_in = d; dp_in = p;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fd(input string nm);
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = frame_done;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL %s: frame_done not seen within 200 cycles", nm); end
  endtask

  task automatic wait_sel(input logic [3:0] tgt, input logic [6:0] seg_exp,
                          input logic dp_exp, input string nm);
    bit got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = (digit_sel == tgt);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s: digit_sel %b not seen within 100 cycles", nm, tgt);
    end else begin
      chk({nm, "_seg"}, segments, seg_exp);
      chk({nm, "_dp"}, dp_out, dp_exp);
    end
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    int n, lit;
    #3;
    chk("reset_sel", digit_sel, 4'b0000);
    chk("reset_seg", segments, 7'h00);
    chk("reset_fd", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;
    pulse_load(16'h1234, 4'b0000);

    // basic scan
    wait_sel(4'b0001, 7'h66, 1'b0, "f1_d0");
    wait_sel(4'b0010, 7'h4F, 1'b0, "f1_d1");
    wait_sel(4'b0100, 7'h5B, 1'b0, "f1_d2");
    wait_sel(4'b1000, 7'h06, 1'b0, "f1_d3");
    wait_fd("period_start");
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_done && n < 100);
    chk("frame_period", n, P);

    // load mid-frame: current frame keeps old data
    wait_sel(4'b0100, 7'h5B, 1'b0, "f3_d2");
    pulse_load(16'h5678, 4'b0000);
    wait_sel(4'b1000, 7'h06, 1'b0, "f3_d3_old");
    wait_sel(4'b0001, 7'h7F, 1'b0, "f4_d0");
    wait_sel(4'b0010, 7'h07, 1'b0, "f4_d1");
    wait_sel(4'b0100, 7'h7D, 1'b0, "f4_d2");
    wait_sel(4'b1000, 7'h6D, 1'b0, "f4_d3");

    // load on the transfer edge: prior shadow shown first, new one a frame later
    pulse_load(16'h1111, 4'b0000);
    wait_fd("fd_before_collide");
    pulse_load(16'h2222, 4'b0001);
    wait_sel(4'b0001, 7'h06, 1'b0, "collide_old");
    wait_fd("fd_after_collide");
    wait_sel(4'b0001, 7'h5B, 1'b1, "collide_new");

    // enable dropped during digit 1
    wait_sel(4'b0010, 7'h5B, 1'b0, "ena_d1");
    lit = 1;
    @(negedge clk);
    chk("ena_d1_lit2", digit_sel, 4'b0010);
    lit++;
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("ena_off_sel", digit_sel, 4'b0000);
      if (i == 0) chk("ena_off_seg", segments, 7'h00);
      if (i == 3) begin load = 1'b1; digits_in = 16'h3333; dp_in = 4'b0000; end
      if (i == 4) load = 1'b0;
    end
    ena = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (digit_sel != 4'b0010) break;
      lit++;
    end
    chk("ena_lit_total", lit, S);

    // asynchronous reset mid-scan
    wait_sel(4'b0100, 7'h5B, 1'b0, "pre_reset_d2");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sel", digit_sel, 4'b0000);
    chk("async_rst_seg", segments, 7'h00);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sel(4'b0001, 7'h3F, 1'b0, "post_reset_d0");

    // zero handling (suppressed when LZ_BLANK_EN is defined)
    pulse_load(16'h0070, 4'b0000);
    wait_fd("fd_0070");
    wait_sel(4'b0001, 7'h3F, 1'b0, "z70_d0");
    wait_sel(4'b0010, 7'h07, 1'b0, "z70_d1");
    wait_sel(4'b0100, ZSEG, 1'b0, "z70_d2");
    wait_sel(4'b1000, ZSEG, 1'b0, "z70_d3");
    pulse_load(16'h0000, 4'b1000);
    wait_fd("fd_0000");
    wait_sel(4'b0001, 7'h3F, 1'b0, "z00_d0");
    wait_sel(4'b0010, ZSEG, 1'b0, "z00_d1");
    wait_sel(4'b0100, ZSEG, 1'b0, "z00_d2");
    wait_sel(4'b1000, ZSEG, 1'b1, "z00_d3");

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
